// File: rtl/alu_muldiv_seq.sv
// Registered RV32I/M execute unit with valid/ready handshake, single-cycle multiply and
// iterative restoring divide. M ops are built only when ALU_MULDIV_EN is defined.
module alu_muldiv_seq #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    logic            init_q, init_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] base_res;
    logic [SHAMT_W-1:0] shamt;
    logic            accept;
    logic            idle;

    // Base RV32I operations
    always_comb begin
        shamt    = b[SHAMT_W-1:0];
        base_res = '0;
        case (alu_op[3:0])
            4'b0000: base_res = a + b;
            4'b1000: base_res = a - b;
            4'b0001: base_res = a << shamt;
            4'b0010: base_res[0] = ($signed(a) < $signed(b));
            4'b0011: base_res[0] = (a < b);
            4'b0100: base_res = a ^ b;
            4'b0101: base_res = a >> shamt;
            4'b1101: base_res = $signed(a) >>> shamt;
            4'b0110: base_res = a | b;
            4'b0111: base_res = a & b;
            default: base_res = '0;
        endcase
    end

    assign in_ready  = init_q && idle && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;

`ifdef ALU_MULDIV_EN

    typedef enum logic {
        S_IDLE,
        S_DIV
    } state_t;

    localparam logic [SHAMT_W:0] CNT_LAST = XLEN[SHAMT_W:0];

    state_t             state_q, state_d;
    logic [SHAMT_W:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    quo_q, quo_d;
    logic [XLEN-1:0]    dvsr_q, dvsr_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               is_rem_q, is_rem_d;
    logic               div0_q, div0_d;

    logic               a_sgn, b_sgn;
    logic [2*XLEN-1:0]  mul_a, mul_b, prod;
    logic [XLEN-1:0]    mul_res;
    logic               div_signed, a_neg, b_neg;
    logic [XLEN:0]      shifted, trial;
    logic [XLEN-1:0]    q_fix, r_fix;

    assign idle = (state_q == S_IDLE);
    assign busy = (state_q == S_DIV);

    // Operands are widened to 2*XLEN with per-op sign fill; the low 2*XLEN bits of the
    // product are exact for every signedness combination.
    always_comb begin
        a_sgn   = (alu_op[1:0] != 2'b11) && a[XLEN-1];
        b_sgn   = (alu_op[1:0] == 2'b00 || alu_op[1:0] == 2'b01) && b[XLEN-1];
        mul_a   = {{XLEN{a_sgn}}, a};
        mul_b   = {{XLEN{b_sgn}}, b};
        prod    = mul_a * mul_b;
        mul_res = (alu_op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d     = state_q;
        init_d      = 1'b1;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        is_rem_d    = is_rem_q;
        div0_d      = div0_q;
        div_signed  = !alu_op[0];
        a_neg       = div_signed && a[XLEN-1];
        b_neg       = div_signed && b[XLEN-1];
        shifted     = {rem_q, quo_q[XLEN-1]};
        trial       = shifted - {1'b0, dvsr_q};
        q_fix       = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        r_fix       = r_neg_q ? (~rem_q + 1'b1) : rem_q;

        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (out_valid_q && out_ready)
                        out_valid_d = 1'b0;
                    if (accept) begin
                        if (alu_op[4] && alu_op[2]) begin
                            state_d  = S_DIV;
                            cnt_d    = '0;
                            rem_d    = '0;
                            quo_d    = a_neg ? (~a + 1'b1) : a;
                            dvsr_d   = b_neg ? (~b + 1'b1) : b;
                            q_neg_d  = a_neg ^ b_neg;
                            r_neg_d  = a_neg;
                            is_rem_d = alu_op[1];
                            div0_d   = (b == '0);
                        end else begin
                            result_d    = alu_op[4] ? mul_res : base_res;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                        if (!trial[XLEN]) begin
                            rem_d = trial[XLEN-1:0];
                            quo_d = {quo_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_d = shifted[XLEN-1:0];
                            quo_d = {quo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        // Divide-by-zero quotient must stay all ones regardless of sign(a)
                        if (is_rem_q)
                            result_d = r_fix;
                        else
                            result_d = div0_q ? '1 : q_fix;
                        out_valid_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            init_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            is_rem_q    <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            is_rem_q    <= is_rem_d;
            div0_q      <= div0_d;
        end
    end

`else

    assign idle = 1'b1;
    assign busy = 1'b0;

    always_comb begin
        init_d      = 1'b1;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready)
                out_valid_d = 1'b0;
            if (accept) begin
                result_d    = alu_op[4] ? '0 : base_res;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            init_q      <= init_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

`endif

endmodule
